// File: rtl/pc_write_ctrl_pkg.sv
// Shared encodings for the multicycle PC-update controller and the instruction decoder.
package pc_write_ctrl_pkg;

  localparam int unsigned Width = 32;

  typedef enum logic [2:0] {
    StIf     = 3'd0,
    StId     = 3'd1,
    StEx     = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalted = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    OpAlu     = 3'd0,
    OpLoad    = 3'd1,
    OpStore   = 3'd2,
    OpBranch  = 3'd3,
    OpJump    = 3'd4,
    OpJr      = 3'd5,
    OpHalt    = 3'd6,
    OpIllegal = 3'd7
  } op_class_e;

  // J-format target: upper nibble of the sequential PC, word-aligned field.
  function automatic logic [Width-1:0] jump_addr(logic [Width-1:0] pc_plus4,
                                                 logic [25:0] target);
    return {pc_plus4[31:28], target, 2'b00};
  endfunction

endpackage

// File: rtl/pc_write_ctrl_if.sv
// Decoder/datapath-facing bus of the PC-update controller.
interface pc_write_ctrl_if;
  import pc_write_ctrl_pkg::*;

  logic [Width-1:0] cur_pc;
  logic             mem_ready;
  logic [2:0]       op_class;
  logic             branch_cond;
  logic [Width-1:0] imm_ext;
  logic [25:0]      jump_target;
  logic [Width-1:0] rs_val;
  logic             w_pc;
  logic [Width-1:0] in_pc;
  logic             ir_write;
  logic [2:0]       state;
  logic             halted;

  modport master (
    input  cur_pc, mem_ready, op_class, branch_cond, imm_ext, jump_target, rs_val,
    output w_pc, in_pc, ir_write, state, halted
  );

  modport slave (
    output cur_pc, mem_ready, op_class, branch_cond, imm_ext, jump_target, rs_val,
    input  w_pc, in_pc, ir_write, state, halted
  );

endinterface

// File: rtl/pc_write_ctrl.sv
// Multicycle PC-update controller: sequences IF/ID/EX/MEM/WB and drives the PC write port.
module pc_write_ctrl
  import pc_write_ctrl_pkg::*;
(
  input  logic             CLK,
  input  logic             reset_n,
  pc_write_ctrl_if.master  pc_bus
);

  state_e           state_q, state_d;
  logic [Width-1:0] pc_plus4_q, pc_plus4_d;
  logic [Width-1:0] seq_pc;
  logic [Width-1:0] in_pc;
  logic             w_pc;
  logic             ir_write;
  op_class_e        op;

  assign seq_pc = pc_bus.cur_pc + 32'd4;
  assign op     = op_class_e'(pc_bus.op_class);

  always_comb begin
    state_d    = state_q;
    pc_plus4_d = pc_plus4_q;
    w_pc       = 1'b0;
    ir_write   = 1'b0;
    in_pc      = '0;
    case (state_q)
      StIf: begin
        if (pc_bus.mem_ready) begin
          ir_write   = 1'b1;
          w_pc       = 1'b1;
          in_pc      = seq_pc;
          pc_plus4_d = seq_pc;
          state_d    = StId;
        end
      end
      StId: begin
        case (op)
          OpJump: begin
            w_pc    = 1'b1;
            in_pc   = jump_addr(pc_plus4_q, pc_bus.jump_target);
            state_d = StIf;
          end
          OpJr: begin
            w_pc    = 1'b1;
            in_pc   = pc_bus.rs_val;
            state_d = StIf;
          end
          OpHalt:    state_d = StHalted;
          OpIllegal: state_d = StIf;
          default:   state_d = StEx;
        endcase
      end
      StEx: begin
        case (op)
          OpBranch: begin
            if (pc_bus.branch_cond) begin
              w_pc  = 1'b1;
              in_pc = pc_plus4_q + (pc_bus.imm_ext << 2);
            end
            state_d = StIf;
          end
          OpAlu:           state_d = StWb;
          OpLoad, OpStore: state_d = StMem;
          default:         state_d = StIf;
        endcase
      end
      StMem: begin
        if (pc_bus.mem_ready) begin
          state_d = (op == OpLoad) ? StWb : StIf;
        end
      end
      StWb:     state_d = StIf;
      StHalted: state_d = StHalted;
      default:  state_d = StIf;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIf;
      pc_plus4_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  // Strobes are gated by reset so an aborted instruction can never write the PC.
  assign pc_bus.w_pc     = w_pc & reset_n;
  assign pc_bus.ir_write = ir_write & reset_n;
  assign pc_bus.in_pc    = reset_n ? in_pc : '0;
  assign pc_bus.state    = state_q;
  assign pc_bus.halted   = (state_q == StHalted);

endmodule

// File: tb/tb_pc_write_ctrl.sv
// Bench for pc_write_ctrl: directed cases plus random instruction streams against a trace model.
module tb_pc_write_ctrl;
  import pc_write_ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic [31:0] pc_reg;
  logic        pc_load;
  logic [31:0] pc_load_val;
  logic [31:0] m_pc;
  int          n_vec = 0;
  int          n_err = 0;

  pc_write_ctrl_if bus ();

  pc_write_ctrl dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .pc_bus  (bus)
  );

  always #5 CLK = ~CLK;

  // PC register model: loads from the controller, or from the bench while in reset.
  always @(posedge CLK) begin
    if (pc_load) pc_reg <= pc_load_val;
    else if (bus.w_pc) pc_reg <= bus.in_pc;
  end
  assign bus.cur_pc = pc_reg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [31:0] pc);
    @(negedge CLK);
    reset_n        = 1'b0;
    pc_load        = 1'b1;
    pc_load_val    = pc;
    bus.mem_ready  = 1'b1;
    #1;
    check("rst_w_pc", bus.w_pc, 0);
    check("rst_in_pc", bus.in_pc, 0);
    check("rst_ir_write", bus.ir_write, 0);
    check("rst_state", bus.state, 0);
    check("rst_halted", bus.halted, 0);
    @(posedge CLK);
    @(negedge CLK);
    reset_n = 1'b1;
    pc_load = 1'b0;
    m_pc    = pc;
  endtask

  // Starts and ends on a falling edge with the controller in IF.
  task automatic run_instr(input op_class_e op, input int s1, input int s2, input logic bc,
                           input logic [31:0] imm, input logic [25:0] jt,
                           input logic [31:0] rs);
    logic [31:0] pc4;
    logic [31:0] fin;
    logic [31:0] exp_w[$];
    state_e      exp_s[$];
    bit          mem_op;
    bit          redirect;
    int          nw;
    int          nir;
    nw       = 0;
    nir      = 0;
    pc4      = m_pc + 32'd4;
    fin      = pc4;
    redirect = 1'b0;
    mem_op   = (op == OpLoad) || (op == OpStore);
    exp_w.push_back(pc4);
    bus.op_class    = op;
    bus.branch_cond = bc;
    bus.imm_ext     = imm;
    bus.jump_target = jt;
    bus.rs_val      = rs;
    repeat (s1 + 1) exp_s.push_back(StIf);
    exp_s.push_back(StId);
    case (op)
      OpJump: begin
        fin      = {pc4[31:28], jt, 2'b00};
        redirect = 1'b1;
      end
      OpJr: begin
        fin      = rs;
        redirect = 1'b1;
      end
      OpBranch: begin
        exp_s.push_back(StEx);
        if (bc) begin
          fin      = pc4 + (imm << 2);
          redirect = 1'b1;
        end
      end
      OpAlu: begin
        exp_s.push_back(StEx);
        exp_s.push_back(StWb);
      end
      OpStore: begin
        exp_s.push_back(StEx);
        repeat (s2 + 1) exp_s.push_back(StMem);
      end
      OpLoad: begin
        exp_s.push_back(StEx);
        repeat (s2 + 1) exp_s.push_back(StMem);
        exp_s.push_back(StWb);
      end
      default: ;
    endcase
    if (redirect) exp_w.push_back(fin);
    foreach (exp_s[k]) begin
      bus.mem_ready = !((k < s1) || (mem_op && k >= s1 + 3 && k < s1 + 3 + s2));
      #1;
      check("state", bus.state, exp_s[k]);
      if (bus.w_pc) begin
        if (nw < exp_w.size()) check("in_pc", bus.in_pc, exp_w[nw]);
        nw++;
      end
      if (bus.ir_write) nir++;
      @(negedge CLK);
    end
    check("end_state", bus.state, (op == OpHalt) ? StHalted : StIf);
    check("end_halted", bus.halted, (op == OpHalt) ? 1 : 0);
    check("n_w_pc", nw, exp_w.size());
    check("n_ir_write", nir, 1);
    check("pc_final", pc_reg, fin);
    m_pc = fin;
  endtask

  initial begin
    logic [2:0] r;
    reset_n         = 1'b0;
    pc_load         = 1'b1;
    pc_load_val     = '0;
    bus.mem_ready   = 1'b1;
    bus.op_class    = '0;
    bus.branch_cond = 1'b0;
    bus.imm_ext     = '0;
    bus.jump_target = '0;
    bus.rs_val      = '0;
    m_pc            = '0;

    do_reset(32'h0);
    run_instr(OpAlu, 0, 0, 1'b0, 32'h0, 26'h0, 32'h0);

    do_reset(32'h100);
    run_instr(OpBranch, 0, 0, 1'b1, 32'hFFFF_FFFE, 26'h0, 32'h0);
    do_reset(32'h100);
    run_instr(OpBranch, 0, 0, 1'b0, 32'hFFFF_FFFE, 26'h0, 32'h0);

    do_reset(32'h3000_0010);
    run_instr(OpJump, 0, 0, 1'b0, 32'h0, 26'h000_0040, 32'h0);
    run_instr(OpJr, 0, 0, 1'b0, 32'h0, 26'h0, 32'h1234);
    run_instr(OpLoad, 2, 3, 1'b0, 32'h0, 26'h0, 32'h0);
    run_instr(OpStore, 1, 2, 1'b0, 32'h0, 26'h0, 32'h0);
    run_instr(OpIllegal, 0, 0, 1'b0, 32'h0, 26'h0, 32'h0);
    run_instr(OpHalt, 0, 0, 1'b0, 32'h0, 26'h0, 32'h0);

    repeat (20) begin
      bus.mem_ready = 1'($urandom);
      bus.op_class  = 3'($urandom);
      #1;
      check("halt_state", bus.state, StHalted);
      check("halt_flag", bus.halted, 1);
      check("halt_w_pc", bus.w_pc, 0);
      check("halt_ir_write", bus.ir_write, 0);
      @(negedge CLK);
    end

    // Abort a taken branch in EX: no redirect may reach the PC.
    do_reset(32'h200);
    bus.op_class    = OpBranch;
    bus.branch_cond = 1'b1;
    bus.imm_ext     = 32'h8;
    bus.mem_ready   = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check("ex_w_pc", bus.w_pc, 1);
    reset_n = 1'b0;
    #1;
    check("abort_w_pc", bus.w_pc, 0);
    check("abort_in_pc", bus.in_pc, 0);
    check("abort_ir_write", bus.ir_write, 0);
    check("abort_state", bus.state, StIf);
    check("abort_halted", bus.halted, 0);
    @(posedge CLK);
    #1;
    check("abort_pc", pc_reg, 32'h204);

    do_reset(32'hFFFF_FFFC);
    run_instr(OpAlu, 0, 0, 1'b0, 32'h0, 26'h0, 32'h0);

    for (int i = 0; i < 200; i++) begin
      int s1;
      int s2;
      r  = 3'($urandom_range(0, 7));
      s1 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : 0;
      s2 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : 0;
      run_instr(op_class_e'(r), s1, s2, 1'($urandom), $urandom, 26'($urandom), $urandom);
      if (op_class_e'(r) == OpHalt) do_reset({$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_write_ctrl.md
# pc_write_ctrl

Multicycle PC-update controller: the writer side of the PC register. It sequences each instruction through fetch/decode/execute/memory/writeback states and produces the PC write strobe `w_pc` and the next-PC value `in_pc`, consumed by the PC register on the same clock edge. It sits between the instruction decoder/ALU flags and the PC register in the multicycle CPU datapath.

## Interface
- No parameters; data width fixed at 32.
- `CLK`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cur_pc`  in  32  current PC, read back from the PC register.
- `mem_ready`  in  1  instruction/data memory access complete this cycle.
- `op_class`  in  3  decoded class, valid from ID onward: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 JR, 6 HALT, 7 illegal.
- `branch_cond`  in  1  branch condition (ALU zero/compare), valid in EX.
- `imm_ext`  in  32  sign-extended immediate.
- `jump_target`  in  26  J-format target field.
- `rs_val`  in  32  register rs value, for JR.
- `w_pc`  out  1  PC write strobe.
- `in_pc`  out  32  next PC value, meaningful only when `w_pc`=1.
- `ir_write`  out  1  instruction register load strobe.
- `state`  out  3  current FSM state, for debug and datapath sequencing.
- `halted`  out  1  high while in HALTED.

## Operation
- States and encodings: IF=0, ID=1, EX=2, MEM=3, WB=4, HALTED=5. Codes 6 and 7 are unreachable and recover to IF.
- Internal register `pc_plus4` (32 bits) is captured in IF.
- IF:
  - Stay in IF while `mem_ready`=0; `w_pc`=0 and `ir_write`=0.
  - On `mem_ready`=1: `ir_write`=1, `w_pc`=1, `in_pc`=`cur_pc`+4 (mod 2^32), `pc_plus4`<=`cur_pc`+4, then go to ID.
- ID:
  - JUMP: `w_pc`=1, `in_pc`={`pc_plus4`[31:28], `jump_target`, 2'b00}; go to IF.
  - JR: `w_pc`=1, `in_pc`=`rs_val`; go to IF. No alignment check is made.
  - HALT: go to HALTED.
  - Illegal class: treated as NOP; go to IF.
  - All other classes: go to EX.
- EX:
  - BRANCH: if `branch_cond`=1, `w_pc`=1 and `in_pc`=`pc_plus4`+(`imm_ext`<<2), truncated to 32 bits. Go to IF whether or not the branch is taken.
  - ALU: go to WB.
  - LOAD/STORE: go to MEM.
- MEM:
  - Stay in MEM while `mem_ready`=0.
  - On `mem_ready`=1: LOAD goes to WB; STORE goes to IF.
- WB: one cycle, then go to IF.
- HALTED: sticky. All strobes stay 0 until `reset_n` is asserted.
- Outputs are combinational from `state` and inputs. `w_pc` is never high outside IF, ID and EX.
- `w_pc` and `ir_write` are forced to 0 while `reset_n`=0.

## Timing
- Reset: asynchronous. `state`=IF, `pc_plus4`=0, `w_pc`=0, `in_pc`=0, `ir_write`=0, `halted`=0.
- Reset asserted mid-instruction aborts it with no PC write. After release, the first fetch occurs when `mem_ready` is next seen high.
- The PC register samples `in_pc` on the same rising edge that ends the state asserting `w_pc`. The controller sees the new `cur_pc` on the next cycle.
- Minimum cycle counts with `mem_ready` held high: JUMP/JR 2, BRANCH 3, ALU 4, STORE 4, LOAD 5, HALT 2 to reach HALTED.
- Each cycle of `mem_ready`=0 in IF or MEM adds exactly one cycle.
- Exactly one `ir_write` pulse per instruction.
- At most two `w_pc` pulses per instruction: the sequential update in IF, plus a redirect in ID or EX.

## Structure
- Shared package holds the state encodings and the `op_class` codes (ALU, LOAD, STORE, BRANCH, JUMP, JR, HALT, ILLEGAL). The decoder uses the same package.
- Single module, no sub-modules. The next-PC adder/mux stays inline.

## Test plan
- Reset, then `cur_pc`=0x0, `mem_ready`=1, ALU:
  - IF cycle gives `w_pc`=1, `in_pc`=0x4, `ir_write`=1.
  - State sequence IF→ID→EX→WB→IF; exactly 4 cycles.
- `cur_pc`=0x100, BRANCH, `imm_ext`=0xFFFFFFFE, `branch_cond`=1:
  - EX gives `w_pc`=1, `in_pc`=0xFC.
  - Repeat with `branch_cond`=0: no `w_pc` in EX, PC ends at 0x104.
- `cur_pc`=0x3000_0010, JUMP, `jump_target`=0x0000040: ID gives `in_pc`=0x3000_0100.
- JR with `rs_val`=0x1234: ID gives `in_pc`=0x1234.
- LOAD with `mem_ready` low for 2 cycles in IF and 3 cycles in MEM: total 10 cycles, one `ir_write`, one `w_pc`.
- HALT: state 5 and `halted`=1 held for 20 cycles with no strobes. Then:
  - Assert `reset_n` low mid-EX of a following run: all outputs 0 immediately, state=IF.
  - Wrap case: `cur_pc`=0xFFFFFFFC gives IF `in_pc`=0x0.
